mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one RAM port among four cache requesters: icache0, dcache0, icache1, dcache1 (two cores).
- Sits between the caches and the RAM model.
- Grants one requester at a time and holds the grant until the RAM reports ACCESS.
- Arbitration order: data requests beat instruction requests. Round-robin between cores within a class. A starvation counter guarantees icache progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, number of consecutive dcache grants after which a pending icache request is forced to win.

Ports:
- CLK  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  2  icache read request, one bit per core.
- iaddr0, iaddr1  in  ADDR_W  icache addresses.
- dREN  in  2  dcache read request, per core.
- dWEN  in  2  dcache write request, per core.
- daddr0, daddr1  in  ADDR_W  dcache addresses.
- dstore0, dstore1  in  DATA_W  dcache write data.
- iwait  out  2  icache stall, per core.
- dwait  out  2  dcache stall, per core.
- iload  out  DATA_W  RAM read data, broadcast to both icaches.
- dload  out  DATA_W  RAM read data, broadcast to both dcaches.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.

Behaviour:
- Reset (async, nRST=0):
  - State IDLE, grant cleared, both round-robin pointers 0 (core0 first), starve counter 0.
  - Outputs: iwait=2'b11, dwait=2'b11, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Asserting nRST mid-transaction aborts it; the RAM is left with enables low. No grant survives reset.
- Wait outputs: every wait bit is 1 except the single granted requester's bit in its completion cycle.
- iload and dload always equal ramload (combinational); they are meaningful only when the matching wait bit is 0.
- Requester active:
  - dcache k is active when dREN[k] or dWEN[k] is set.
  - If dREN[k] and dWEN[k] are both set, it is a write.
- IDLE: each cycle, select a winner from the active requesters and register the grant. Move to SERVE only if some request is active; RAM enables stay 0 during IDLE.
- Winner selection order:
  - If starve counter ≥ STARVE_MAX and any iREN is set, the icache class wins.
  - Otherwise the dcache class wins if any dcache is active, else the icache class.
  - Within a class, the core equal to that class's pointer wins if active, else the other core.
- SERVE:
  - Drive ramREN/ramWEN/ramaddr/ramstore from the granted requester. ramstore=0 for reads.
  - ramstate FREE or BUSY: hold the grant and keep signals stable.
  - ramstate ERROR: treat as BUSY. Hold and retry; no wait release.
  - ramstate ACCESS: in that same cycle, drop the granted requester's wait to 0. Then:
    - Toggle that class's pointer to the other core.
    - Update starve counter: +1 (saturating at STARVE_MAX) if a dcache was served while any iREN was set; reset to 0 if an icache was served or no iREN was set.
    - Return to IDLE.
  - Granted requester deasserts its request while in SERVE (no ACCESS this cycle): abort. Enables go to 0 next cycle, return to IDLE, pointer and counter unchanged.
- Latency: minimum 2 cycles from request to wait=0. Cycle 1 is IDLE (grant registered). Cycle 2 is SERVE with ACCESS.
- Back-to-back requests always pass through one IDLE cycle.
- Granted requester's address or data changing mid-SERVE: the new values are forwarded straight through; the grant is not re-arbitrated.

Test Plan:
- Single read: dREN[0]=1, daddr0=0x100, ramstate goes ACCESS 2 cycles after grant, ramload=0xDEADBEEF → ramREN=1, ramaddr=0x100, dwait[0]=0 for exactly one cycle, dload=0xDEADBEEF, other waits stay 1.
- Class priority: iREN[0], dWEN[1] raised together, ramstate=ACCESS every SERVE cycle, dstore1=0x5 → dcache1 served first (ramWEN=1, ramstore=0x5); icache0 served on the next grant.
- Round-robin: dREN=2'b11 held continuously, immediate ACCESS → grants alternate core0, core1, core0, core1.
- Starvation: dREN=2'b11 and iREN[0]=1 held, STARVE_MAX=4 → 4 dcache grants, then icache0 granted (iwait[0]=0), then dcache resumes with starve counter 0.
- Abort and ERROR:
  - dREN[0] dropped during SERVE with ramstate=BUSY → ramREN=0 next cycle, no wait released, next winner unaffected.
  - ramstate=ERROR for 3 cycles then ACCESS → signals held stable, one release.
- Async reset mid-SERVE: nRST pulled low → ramREN=0 and ramWEN=0 immediately, all waits 1. After release, the first grant follows core0 pointer order.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares a single RAM port between four cache requesters: icache0, dcache0,
//   icache1 and dcache1 (two cores). One requester is granted at a time and
//   keeps the grant until the RAM reports ACCESS. Data requests beat
//   instruction requests, each class round-robins between the two cores, and
//   a starvation counter forces a pending icache request through after
//   STARVE_MAX consecutive dcache grants.
//
//   Request/wait handshake: a requester holds its request (iREN, dREN or dWEN)
//   high and keeps its address/data stable until it sees its wait bit at 0.
//   A wait bit is 0 for exactly one cycle, the cycle in which the RAM reports
//   ACCESS for that requester; read data is valid on iload/dload in that same
//   cycle. Dropping a request before that cycle abandons the access.
//
// Ports:
//   CLK, nRST            clock, asynchronous active-low reset
//   iREN[1:0]            icache read request per core
//   iaddr0, iaddr1       icache addresses
//   dREN[1:0], dWEN[1:0] dcache read/write request per core (both set = write)
//   daddr0, daddr1       dcache addresses
//   dstore0, dstore1     dcache write data
//   iwait[1:0]           icache stall per core
//   dwait[1:0]           dcache stall per core
//   iload, dload         RAM read data broadcast to the caches
//   ramREN, ramWEN       RAM read/write enables
//   ramaddr, ramstore    RAM address and write data
//   ramload              RAM read data
//   ramstate             RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [1:0]        iREN,
    input  logic [ADDR_W-1:0] iaddr0,
    input  logic [ADDR_W-1:0] iaddr1,
    input  logic [1:0]        dREN,
    input  logic [1:0]        dWEN,
    input  logic [ADDR_W-1:0] daddr0,
    input  logic [ADDR_W-1:0] daddr1,
    input  logic [DATA_W-1:0] dstore0,
    input  logic [DATA_W-1:0] dstore1,
    output logic [1:0]        iwait,
    output logic [1:0]        dwait,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    localparam int              SW         = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [1:0]      RAM_ACCESS = 2'b10;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_dc_q, gnt_dc_d;      // 1: dcache class granted
    logic          gnt_core_q, gnt_core_d;  // granted core index
    logic          gnt_wr_q, gnt_wr_d;      // granted access is a write
    logic          ipnt_q, ipnt_d;          // icache round-robin pointer
    logic          dpnt_q, dpnt_d;          // dcache round-robin pointer
    logic [SW-1:0] starve_q, starve_d;

    logic [1:0]    dact;
    logic          any_i, any_d;
    logic          sel_icls, sel_core, sel_wr;
    logic          gnt_act;

    assign dact  = dREN | dWEN;
    assign any_i = |iREN;
    assign any_d = |dact;

    // Read data is broadcast; it only matters where the wait bit is low.
    assign iload = ramload;
    assign dload = ramload;

    // Winner selection for the IDLE cycle.
    always_comb begin
        sel_icls = 1'b0;
        sel_core = 1'b0;
        sel_wr   = 1'b0;
        // A starved icache overrides data priority; otherwise icache only
        // wins when no dcache is asking.
        if ((starve_q >= STARVE_LIM && any_i) || !any_d) begin
            sel_icls = 1'b1;
            sel_core = iREN[ipnt_q] ? ipnt_q : ~ipnt_q;
        end else begin
            sel_core = dact[dpnt_q] ? dpnt_q : ~dpnt_q;
            sel_wr   = dWEN[sel_core];
        end
    end

    // Whether the granted requester still holds its request.
    assign gnt_act = gnt_dc_q ? dact[gnt_core_q] : iREN[gnt_core_q];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            gnt_dc_q   <= 1'b0;
            gnt_core_q <= 1'b0;
            gnt_wr_q   <= 1'b0;
            ipnt_q     <= 1'b0;
            dpnt_q     <= 1'b0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_dc_q   <= gnt_dc_d;
            gnt_core_q <= gnt_core_d;
            gnt_wr_q   <= gnt_wr_d;
            ipnt_q     <= ipnt_d;
            dpnt_q     <= dpnt_d;
            starve_q   <= starve_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_dc_d   = gnt_dc_q;
        gnt_core_d = gnt_core_q;
        gnt_wr_d   = gnt_wr_q;
        ipnt_d     = ipnt_q;
        dpnt_d     = dpnt_q;
        starve_d   = starve_q;
        iwait      = 2'b11;
        dwait      = 2'b11;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;

        case (state_q)
            IDLE: begin
                if (any_i || any_d) begin
                    gnt_dc_d   = ~sel_icls;
                    gnt_core_d = sel_core;
                    gnt_wr_d   = sel_wr;
                    state_d    = SERVE;
                end
            end

            SERVE: begin
                // The operation type is latched at grant time so an abort
                // only drops the enables on the following IDLE cycle; address
                // and data are forwarded live from the granted requester.
                ramREN = ~gnt_wr_q;
                ramWEN = gnt_wr_q;
                if (gnt_dc_q) begin
                    ramaddr = gnt_core_q ? daddr1 : daddr0;
                    if (gnt_wr_q) begin
                        ramstore = gnt_core_q ? dstore1 : dstore0;
                    end
                end else begin
                    ramaddr = gnt_core_q ? iaddr1 : iaddr0;
                end

                // FREE, BUSY and ERROR all hold the grant; ERROR is retried.
                if (ramstate == RAM_ACCESS) begin
                    if (gnt_dc_q) begin
                        dwait[gnt_core_q] = 1'b0;
                        dpnt_d            = ~gnt_core_q;
                        if (any_i) begin
                            starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM
                                                                : starve_q + SW'(1);
                        end else begin
                            starve_d = '0;
                        end
                    end else begin
                        iwait[gnt_core_q] = 1'b0;
                        ipnt_d            = ~gnt_core_q;
                        starve_d          = '0;
                    end
                    state_d = IDLE;
                end else if (!gnt_act) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int DW = 32;
  // {dwait, iwait, ramREN, ramWEN, ramaddr, ramstore, load}
  localparam int W = 2 + 2 + 1 + 1 + 3 * DW;

  logic          CLK;
  logic          nRST;
  logic [1:0]    iREN, dREN, dWEN;
  logic [31:0]   iaddr0, iaddr1, daddr0, daddr1, dstore0, dstore1;
  logic [1:0]    iwait, dwait;
  logic [31:0]   iload, dload;
  logic          ramREN, ramWEN;
  logic [31:0]   ramaddr, ramstore, ramload;
  logic [1:0]    ramstate;

  // RAM model: auto mode answers ACCESS whenever an enable is up,
  // manual mode presents rs_man.
  logic          ram_auto;
  logic [1:0]    rs_man;
  logic [31:0]   ram_data;

  assign ramstate = ram_auto ? ((ramREN || ramWEN) ? 2'b10 : 2'b00) : rs_man;
  assign ramload  = ram_data;

  logic [W-1:0]  exp_q[$];
  int            checks = 0;
  int            errors = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .iREN     (iREN),
    .iaddr0   (iaddr0),
    .iaddr1   (iaddr1),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr0   (daddr0),
    .daddr1   (daddr1),
    .dstore0  (dstore0),
    .dstore1  (dstore1),
    .iwait    (iwait),
    .dwait    (dwait),
    .iload    (iload),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic dc, input logic core, input logic wr,
                                      input logic [31:0] addr, input logic [31:0] store,
                                      input logic [31:0] load);
    logic [1:0] w;
    w = core ? 2'b01 : 2'b10;
    return {dc ? w : 2'b11, dc ? 2'b11 : w, ~wr, wr, addr, wr ? store : 32'h0, load};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Waits (bounded) for the next wait release, then moves to the next
  // posedge+1 so the requester can drop its request.
  task automatic wait_rel(input string name);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge CLK);
      if ({dwait, iwait} != 4'hF) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: got no wait release, expected one within 20 cycles", name);
    end
    step();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLK) begin : monitor
    logic [W-1:0] obs;
    logic [W-1:0] exp_v;
    if ({dwait, iwait} != 4'hF) begin
      obs = {dwait, iwait, ramREN, ramWEN, ramaddr, ramstore,
             (dwait != 2'b11) ? dload : iload};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL release: got %h, expected no release", obs);
      end else begin
        exp_v = exp_q.pop_front();
        if (obs !== exp_v) begin
          errors++;
          $display("FAIL release: got %h, expected %h", obs, exp_v);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    nRST = 1'b0;
    iREN = 2'b00; dREN = 2'b00; dWEN = 2'b00;
    iaddr0 = '0; iaddr1 = '0; daddr0 = '0; daddr1 = '0;
    dstore0 = '0; dstore1 = '0;
    ram_auto = 1'b0; rs_man = 2'b00; ram_data = '0;

    // Reset state
    repeat (2) step();
    @(negedge CLK);
    chk("reset waits",   {60'h0, iwait, dwait}, 64'hF);
    chk("reset enables", {62'h0, ramREN, ramWEN}, 64'h0);
    chk("reset ramaddr", {32'h0, ramaddr}, 64'h0);
    chk("reset ramstore", {32'h0, ramstore}, 64'h0);
    nRST = 1'b1;
    step();
    @(negedge CLK);
    chk("idle waits",   {60'h0, iwait, dwait}, 64'hF);
    chk("idle enables", {62'h0, ramREN, ramWEN}, 64'h0);
    step();

    // Single read by dcache0, ACCESS arrives on the second SERVE cycle
    ram_data = 32'hDEADBEEF;
    daddr0   = 32'h100;
    dREN     = 2'b01;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF));
    step();
    @(negedge CLK);
    chk("t1 serve ramREN", {63'h0, ramREN}, 64'h1);
    chk("t1 serve ramaddr", {32'h0, ramaddr}, 64'h100);
    chk("t1 serve waits", {60'h0, iwait, dwait}, 64'hF);
    step();
    rs_man = 2'b10;
    wait_rel("t1 release");
    dREN   = 2'b00;
    rs_man = 2'b00;

    // Class priority: dcache1 write beats icache0 read
    ram_auto = 1'b1;
    ram_data = 32'h11111111;
    iaddr0   = 32'h300;
    daddr1   = 32'h200;
    dstore1  = 32'h5;
    iREN     = 2'b01;
    dWEN     = 2'b10;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 32'h200, 32'h5, 32'h11111111));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h11111111));
    wait_rel("t2 dcache1");
    dWEN = 2'b00;
    wait_rel("t2 icache0");
    iREN = 2'b00;

    // Round-robin between dcache cores
    ram_data = 32'h22222222;
    daddr0   = 32'h400;
    daddr1   = 32'h500;
    dREN     = 2'b11;
    for (int c = 0; c < 4; c++)
      exp_q.push_back(mk(1'b1, c[0], 1'b0, c[0] ? 32'h500 : 32'h400, 32'h0, 32'h22222222));
    repeat (4) wait_rel("t3 rr");
    dREN = 2'b00;

    // Starvation: four dcache grants, then icache0, twice over
    ram_data = 32'h33333333;
    dREN     = 2'b11;
    iREN     = 2'b01;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++)
        exp_q.push_back(mk(1'b1, c[0], 1'b0, c[0] ? 32'h500 : 32'h400, 32'h0, 32'h33333333));
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h33333333));
    end
    repeat (10) wait_rel("t4 starve");
    dREN = 2'b00;
    iREN = 2'b00;

    // Abort: dcache0 drops its read during a BUSY SERVE
    ram_auto = 1'b0;
    rs_man   = 2'b01;
    daddr0   = 32'h600;
    dREN     = 2'b01;
    step();
    @(negedge CLK);
    chk("t5 serve ramREN", {63'h0, ramREN}, 64'h1);
    step();
    dREN = 2'b00;
    step();
    @(negedge CLK);
    chk("t5 after abort enables", {62'h0, ramREN, ramWEN}, 64'h0);
    chk("t5 after abort waits", {60'h0, iwait, dwait}, 64'hF);
    step();
    ram_auto = 1'b1;
    ram_data = 32'h44444444;
    dREN     = 2'b11;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 32'h600, 32'h0, 32'h44444444));
    wait_rel("t5 next winner");
    dREN = 2'b00;

    // ERROR for three cycles, then ACCESS
    ram_auto = 1'b0;
    rs_man   = 2'b11;
    ram_data = 32'h66666666;
    daddr1   = 32'h700;
    dstore1  = 32'hABCD;
    dWEN     = 2'b10;
    exp_q.push_back(mk(1'b1, 1'b1, 1'b1, 32'h700, 32'hABCD, 32'h66666666));
    step();
    for (int e = 0; e < 3; e++) begin
      @(negedge CLK);
      chk("t6 error enables", {62'h0, ramREN, ramWEN}, 64'h1);
      chk("t6 error ramaddr", {32'h0, ramaddr}, 64'h700);
      chk("t6 error ramstore", {32'h0, ramstore}, 64'hABCD);
      chk("t6 error waits", {60'h0, iwait, dwait}, 64'hF);
      step();
    end
    rs_man = 2'b10;
    wait_rel("t6 release");
    dWEN   = 2'b00;
    rs_man = 2'b00;

    // Async reset in the middle of SERVE
    rs_man = 2'b01;
    daddr1 = 32'h500;
    dREN   = 2'b10;
    step();
    @(negedge CLK);
    chk("t7 serve ramREN", {63'h0, ramREN}, 64'h1);
    #2;
    nRST = 1'b0;
    #1;
    chk("t7 reset enables", {62'h0, ramREN, ramWEN}, 64'h0);
    chk("t7 reset waits", {60'h0, iwait, dwait}, 64'hF);
    dREN = 2'b00;
    @(negedge CLK);
    nRST = 1'b1;
    step();
    ram_auto = 1'b1;
    ram_data = 32'h55555555;
    iaddr1   = 32'h800;
    iREN     = 2'b11;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 32'h300, 32'h0, 32'h55555555));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 32'h800, 32'h0, 32'h55555555));
    repeat (2) wait_rel("t7 post-reset");
    iREN = 2'b00;

    repeat (3) step();
    chk("expected queue drained", 64'(exp_q.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
